param_shift_unit: RTL and testbench
===================================

Name: param_shift_unit

Overview:
- Parametrised successor to the fixed-width arithmetic-right-shift controller.
- Integrates FSM and datapath: captures a WIDTH-bit operand on Start, then shifts it iteratively, one bit per clock.
- Four modes: SRA, SRL, SLL, ROR.
- Signals completion with a one-cycle DONE pulse; result holds until the next accepted Start.
- Used wherever the datapath needs a small, area-cheap variable shifter.

Parameters:
- WIDTH, 8, operand/result width in bits, legal values WIDTH ≥ 2.
- AW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled only in IDLE.
- mode  input  2  00 SRA, 01 SRL, 10 SLL, 11 ROR; captured with Start.
- amount  input  AW  shift count, 0..WIDTH-1; captured with Start.
- din  input  WIDTH  operand; captured with Start.
- dout  output  WIDTH  shift register contents; final result once DONE pulses.
- busy  output  1  high in SHIFT and FIN.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; dout=0; busy=0; DONE=0; internal count=0; captured mode=0.
  - Reset asserted mid-operation aborts immediately.
  - No DONE is produced for the aborted job.
- States: IDLE, SHIFT, FIN.
- IDLE:
  - On an edge with Start=1 ("edge 0"): dout<=din; capture mode and amount; cnt<=amount.
  - Next state is SHIFT if amount≠0, else FIN.
  - Start=0: remain in IDLE; dout holds.
- SHIFT: each edge applies one single-bit step to dout in the captured mode, then cnt<=cnt-1. Go to FIN when cnt==1 before decrement.
  - SRA: fill the vacated MSB with the old MSB.
  - SRL: fill the vacated MSB with 0.
  - SLL: fill the vacated LSB with 0.
  - ROR: old LSB moves to the MSB.
- FIN: DONE=1 for exactly this cycle; next edge goes to IDLE; dout holds.
- Latency: DONE is high in the cycle after edge A, where A=amount.
  - amount=0 gives DONE in the cycle after edge 0, with dout=din.
  - Total occupancy is A+2 cycles including the FIN-to-IDLE return.
- Start outside IDLE (SHIFT or FIN) is ignored. No queuing; the requester must re-assert Start.
- mode, amount and din may change freely after capture without effect.
- amount is unsigned. An amount of WIDTH-1 fully drains SRL/SLL to 0 except for one bit. Values ≥ WIDTH cannot occur for power-of-two WIDTH.
  - For non-power-of-two WIDTH, captured amounts ≥ WIDTH are clamped to WIDTH-1.
- dout, busy and DONE are registered or decoded directly from state. No combinational path from inputs to outputs.

Optional Feature:
- Macro: SHIFT_STICKY_EN.
- Defined: adds output port `sticky` (1 bit).
  - Cleared to 0 on reset and on Start capture.
  - In SHIFT with mode SRA or SRL, sticky<=sticky | dout[0] before each step.
  - Stays 0 for SLL and ROR.
  - Valid with DONE; holds until the next capture.
- Not defined: no sticky port and no associated logic. All other behaviour is identical.

Decomposition:
- Package shift_pkg:
  - Mode encodings MODE_SRA=2'b00, MODE_SRL=2'b01, MODE_SLL=2'b10, MODE_ROR=2'b11.
  - State encodings ST_IDLE, ST_SHIFT, ST_FIN.
- Sub-module shift_step: purely combinational, parametrised by WIDTH. Inputs are the data and mode; output is the data shifted by one bit. Instantiated once in the datapath.
- The FSM and counter stay in param_shift_unit.

Test Plan:
- WIDTH=8, din=8'b1001_0110, amount=3:
  - SRA -> DONE in cycle after edge 3, dout=8'b1111_0010.
  - SRL -> dout=8'b0001_0010.
  - SLL -> dout=8'b1011_0000.
  - ROR -> dout=8'b1101_0010.
- amount=0, SRA, din=8'hA5 -> DONE in cycle after edge 0, dout=8'hA5, busy high for that FIN cycle only.
- Start pulsed every cycle during an amount=5 job, with different din/mode -> result unaffected and exactly one DONE. A new job is accepted only once the FSM is back in IDLE.
- rst_n driven low asynchronously between edges 2 and 3 of an amount=6 job -> dout=0, busy=0, DONE=0 immediately; no DONE after release; next Start works normally.
- WIDTH=16, SRA, din=16'h8001, amount=15 -> DONE in cycle after edge 15, dout=16'hFFFF. SRL with the same inputs -> dout=16'h0001.
- SHIFT_STICKY_EN defined, WIDTH=8, din=8'b1001_0110:
  - SRL by 3 -> sticky=1.
  - SRL by 1 -> sticky=0.
  - SLL by 3 -> sticky=0.

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pkg
//  Brief    : Shared mode and state encodings for param_shift_unit.
//  Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

  // Shift mode encodings, as presented on the mode input
  typedef enum logic [1:0] {
    MODE_SRA = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SLL = 2'b10,
    MODE_ROR = 2'b11
  } mode_t;

  // Controller state encodings
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_FIN   = 2'b10
  } state_t;

  // True for the modes that shift bits out of the LSB end and discard them
  function automatic logic is_right_shift(input mode_t m);
    return (m == MODE_SRA) || (m == MODE_SRL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
//  Module   : shift_step
//  Brief    : Combinational single-bit shift/rotate of a WIDTH-bit word.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  input  mode_t            mode,
  output logic [WIDTH-1:0] dout
);

  // Apply exactly one bit of shift in the selected mode
  always_comb begin
    dout = din;
    case (mode)
      MODE_SRA: dout = {din[WIDTH-1], din[WIDTH-1:1]};
      MODE_SRL: dout = {1'b0, din[WIDTH-1:1]};
      MODE_SLL: dout = {din[WIDTH-2:0], 1'b0};
      MODE_ROR: dout = {din[0], din[WIDTH-1:1]};
      default:  dout = din;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/param_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : param_shift_unit
//  Brief    : Iterative one-bit-per-clock shifter (SRA/SRL/SLL/ROR) with a
//             Start/DONE handshake. Operand, mode and amount are captured on
//             Start in IDLE; DONE pulses for one cycle when the result is ready.
//  Options  : `define SHIFT_STICKY_EN adds a 'sticky' output that ORs together
//             every bit shifted out of the LSB during SRA/SRL.
//  Revision : 1.0 - initial release
// ============================================================================
module param_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    amount,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             DONE
`ifdef SHIFT_STICKY_EN
  ,
  output logic             sticky
`endif
);

  localparam logic [AW-1:0] c_max_amt = AW'(WIDTH - 1);
  localparam logic [AW-1:0] c_one     = AW'(1);

  state_t           r_state;
  mode_t            r_mode;
  logic [AW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic [AW-1:0]    w_amount;
  logic [WIDTH-1:0] w_step;

  // Only a non-power-of-two width can encode counts beyond WIDTH-1
  generate
    if ((1 << AW) > WIDTH) begin : g_clamp
      assign w_amount = (amount > c_max_amt) ? c_max_amt : amount;
    end else begin : g_no_clamp
      assign w_amount = amount;
    end
  endgenerate

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .din  (r_dout),
    .mode (r_mode),
    .dout (w_step)
  );

  // Controller and datapath: capture in IDLE, one step per clock in SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_SRA;
      r_cnt   <= '0;
      r_dout  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_dout  <= din;
            r_mode  <= mode_t'(mode);
            r_cnt   <= w_amount;
            r_state <= (w_amount != '0) ? ST_SHIFT : ST_FIN;
          end
        end
        ST_SHIFT: begin
          r_dout <= w_step;
          r_cnt  <= r_cnt - c_one;
          if (r_cnt == c_one) begin
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout = r_dout;
  assign busy = (r_state != ST_IDLE);
  assign DONE = (r_state == ST_FIN);

`ifdef SHIFT_STICKY_EN
  logic r_sticky;

  // Accumulate bits lost off the LSB end; cleared on each new capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if ((r_state == ST_IDLE) && Start) begin
      r_sticky <= 1'b0;
    end else if ((r_state == ST_SHIFT) && is_right_shift(r_mode)) begin
      r_sticky <= r_sticky | r_dout[0];
    end
  end

  assign sticky = r_sticky;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_shift_unit
//  Brief    : Directed self-checking bench for param_shift_unit at WIDTH=8
//             and WIDTH=16 (sticky checks when SHIFT_STICKY_EN is defined).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_shift_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0;
  logic [1:0]  mode8  = 2'b00;
  logic [2:0]  amt8   = 3'd0;
  logic [7:0]  din8   = 8'h00;
  logic [7:0]  dout8;
  logic        busy8;
  logic        done8;

  logic        start16 = 1'b0;
  logic [1:0]  mode16  = 2'b00;
  logic [3:0]  amt16   = 4'd0;
  logic [15:0] din16   = 16'h0000;
  logic [15:0] dout16;
  logic        busy16;
  logic        done16;

`ifdef SHIFT_STICKY_EN
  logic        sticky8;
  logic        sticky16;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  param_shift_unit #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .Start  (start8),
    .mode   (mode8),
    .amount (amt8),
    .din    (din8),
    .dout   (dout8),
    .busy   (busy8),
    .DONE   (done8)
`ifdef SHIFT_STICKY_EN
    ,
    .sticky (sticky8)
`endif
  );

  param_shift_unit #(.WIDTH(16)) u_dut16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .Start  (start16),
    .mode   (mode16),
    .amount (amt16),
    .din    (din16),
    .dout   (dout16),
    .busy   (busy16),
    .DONE   (done16)
`ifdef SHIFT_STICKY_EN
    ,
    .sticky (sticky16)
`endif
  );

  // Issue one job to the 8-bit unit and return in its DONE cycle.
  // edges = number of clock edges after edge 0 until DONE, -1 on timeout.
  task automatic run8(input logic [1:0] m, input logic [2:0] a,
                      input logic [7:0] d, output int edges);
    start8 = 1'b1; mode8 = m; amt8 = a; din8 = d;
    @(posedge clk); #1;
    start8 = 1'b0; mode8 = ~m; amt8 = ~a; din8 = ~d;
    edges = 0;
    while (!done8 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!done8) edges = -1;
  endtask

  task automatic run16(input logic [1:0] m, input logic [3:0] a,
                       input logic [15:0] d, output int edges);
    start16 = 1'b1; mode16 = m; amt16 = a; din16 = d;
    @(posedge clk); #1;
    start16 = 1'b0; mode16 = ~m; amt16 = ~a; din16 = ~d;
    edges = 0;
    while (!done16 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!done16) edges = -1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (dout8 !== 8'h00) begin n_fail++; $display("FAIL reset_dout8 got=%h exp=%h", dout8, 8'h00); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done8 got=%b exp=0", done8); end
    n_checks++; if (dout16 !== 16'h0000) begin n_fail++; $display("FAIL reset_dout16 got=%h exp=0000", dout16); end
`ifdef SHIFT_STICKY_EN
    n_checks++; if (sticky8 !== 1'b0) begin n_fail++; $display("FAIL reset_sticky8 got=%b exp=0", sticky8); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL idle_busy8 got=%b exp=0", busy8); end
  endtask

  task automatic test_modes();
    logic [7:0] exp_v [4];
    int e;
    exp_v = '{8'hF2, 8'h12, 8'hB0, 8'hD2};
    for (int i = 0; i < 4; i++) begin
      run8(2'(i), 3'd3, 8'h96, e);
      n_checks++; if (e !== 3) begin n_fail++; $display("FAIL mode%0d_latency got=%0d exp=3", i, e); end
      n_checks++; if (dout8 !== exp_v[i]) begin n_fail++; $display("FAIL mode%0d_dout got=%h exp=%h", i, dout8, exp_v[i]); end
      n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL mode%0d_busy_fin got=%b exp=1", i, busy8); end
      @(posedge clk); #1;
      n_checks++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin n_fail++; $display("FAIL mode%0d_return got done=%b busy=%b exp 0/0", i, done8, busy8); end
      n_checks++; if (dout8 !== exp_v[i]) begin n_fail++; $display("FAIL mode%0d_hold got=%h exp=%h", i, dout8, exp_v[i]); end
    end
  endtask

  task automatic test_amount_zero();
    int e;
    run8(2'b00, 3'd0, 8'hA5, e);
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL amt0_latency got=%0d exp=0", e); end
    n_checks++; if (dout8 !== 8'hA5) begin n_fail++; $display("FAIL amt0_dout got=%h exp=a5", dout8); end
    n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL amt0_busy_fin got=%b exp=1", busy8); end
    @(posedge clk); #1;
    n_checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin n_fail++; $display("FAIL amt0_return got busy=%b done=%b exp 0/0", busy8, done8); end
  endtask

  task automatic test_back_to_back();
    int edges;
    int pulses;
    int done_edge;
    logic [7:0] done_val;
    start8 = 1'b1; mode8 = 2'b00; amt8 = 3'd5; din8 = 8'h96;
    @(posedge clk); #1;
    edges = 0; pulses = 0; done_edge = -1; done_val = 8'h00;
    while (edges < 20 && !(edges > 0 && !busy8)) begin
      start8 = 1'b1;
      din8   = 8'(edges * 37 + 1);
      mode8  = 2'(edges + 1);
      amt8   = 3'(edges + 2);
      @(posedge clk); #1;
      edges++;
      if (done8) begin pulses++; done_edge = edges; done_val = dout8; end
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL b2b_done_pulses got=%0d exp=1", pulses); end
    n_checks++; if (done_edge !== 5) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=5", done_edge); end
    n_checks++; if (done_val !== 8'hFC) begin n_fail++; $display("FAIL b2b_dout got=%h exp=fc", done_val); end
    n_checks++; if (edges !== 6) begin n_fail++; $display("FAIL b2b_idle_edge got=%0d exp=6", edges); end
    // Start still held in IDLE: the next edge must accept a new job
    din8 = 8'h81; mode8 = 2'b10; amt8 = 3'd1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n_checks++; if (busy8 !== 1'b1 || dout8 !== 8'h81) begin n_fail++; $display("FAIL b2b_accept got busy=%b dout=%h exp 1/81", busy8, dout8); end
    @(posedge clk); #1;
    n_checks++; if (done8 !== 1'b1 || dout8 !== 8'h02) begin n_fail++; $display("FAIL b2b_second got done=%b dout=%h exp 1/02", done8, dout8); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int e;
    int pulses;
    int busy_seen;
    start8 = 1'b1; mode8 = 2'b01; amt8 = 3'd6; din8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (dout8 !== 8'h00) begin n_fail++; $display("FAIL abort_dout got=%h exp=00", dout8); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy8); end
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done8); end
    #2 rst_n = 1'b1;
    pulses = 0; busy_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done8) pulses++;
      if (busy8) busy_seen++;
    end
    n_checks++; if (pulses !== 0 || busy_seen !== 0) begin n_fail++; $display("FAIL abort_no_done got done=%0d busy=%0d exp 0/0", pulses, busy_seen); end
    run8(2'b10, 3'd2, 8'h03, e);
    n_checks++; if (e !== 2) begin n_fail++; $display("FAIL post_abort_latency got=%0d exp=2", e); end
    n_checks++; if (dout8 !== 8'h0C) begin n_fail++; $display("FAIL post_abort_dout got=%h exp=0c", dout8); end
    @(posedge clk); #1;
  endtask

  task automatic test_width16();
    int e;
    run16(2'b00, 4'd15, 16'h8001, e);
    n_checks++; if (e !== 15) begin n_fail++; $display("FAIL w16_sra_latency got=%0d exp=15", e); end
    n_checks++; if (dout16 !== 16'hFFFF) begin n_fail++; $display("FAIL w16_sra_dout got=%h exp=ffff", dout16); end
    @(posedge clk); #1;
    run16(2'b01, 4'd15, 16'h8001, e);
    n_checks++; if (e !== 15) begin n_fail++; $display("FAIL w16_srl_latency got=%0d exp=15", e); end
    n_checks++; if (dout16 !== 16'h0001) begin n_fail++; $display("FAIL w16_srl_dout got=%h exp=0001", dout16); end
    @(posedge clk); #1;
  endtask

`ifdef SHIFT_STICKY_EN
  task automatic test_sticky();
    int e;
    run8(2'b01, 3'd3, 8'h96, e);
    n_checks++; if (sticky8 !== 1'b1) begin n_fail++; $display("FAIL sticky_srl3 got=%b exp=1", sticky8); end
    @(posedge clk); #1;
    run8(2'b01, 3'd1, 8'h96, e);
    n_checks++; if (sticky8 !== 1'b0) begin n_fail++; $display("FAIL sticky_srl1 got=%b exp=0", sticky8); end
    @(posedge clk); #1;
    run8(2'b10, 3'd3, 8'h96, e);
    n_checks++; if (sticky8 !== 1'b0) begin n_fail++; $display("FAIL sticky_sll3 got=%b exp=0", sticky8); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_modes();
    test_amount_zero();
    test_back_to_back();
    test_reset_abort();
    test_width16();
`ifdef SHIFT_STICKY_EN
    test_sticky();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
